// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fib_pkg
// Purpose  : Shared state encodings, read-latency default and the
//            term-count clamp helper for the Fibonacci SRAM master.
// Revision : 1.0 - initial release
// ============================================================================
package fib_pkg;

  // The current SRAM wrapper needs two clock edges from address+oe to data.
  localparam int RD_LATENCY_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GEN      = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_RESP  = 3'd4
  } state_e;

  // Limit a requested term count to the SRAM capacity of 2^aw terms.
  function automatic int unsigned clamp_count(input int unsigned cnt,
                                              input int unsigned aw);
    int unsigned cap;
    cap = 32'd1 << aw;
    return (cnt > cap) ? cap : cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fib_term_gen.sv
`default_nettype none
// ============================================================================
// Module   : fib_term_gen
// Purpose  : Fibonacci term pair (a, b) with per-term overflow tags. The
//            current term is a; each advance shifts the pair one step.
// Revision : 1.0 - initial release
// ============================================================================
module fib_term_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] term_o,
  output logic                  term_ovf_o
);

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  a_tag_q, a_tag_d;
  logic                  b_tag_q, b_tag_d;
  logic [DATA_WIDTH:0]   w_sum;

  // Next pair: load restarts at (0, 1); advance computes a+b, carrying the
  // tag of either operand plus any carry-out into the new term.
  always_comb begin
    w_sum   = {1'b0, a_q} + {1'b0, b_q};
    a_d     = a_q;
    b_d     = b_q;
    a_tag_d = a_tag_q;
    b_tag_d = b_tag_q;
    if (load_i) begin
      a_d     = '0;
      b_d     = DATA_WIDTH'(1);
      a_tag_d = 1'b0;
      b_tag_d = 1'b0;
    end else if (advance_i) begin
      a_d     = b_q;
      b_d     = w_sum[DATA_WIDTH-1:0];
      a_tag_d = b_tag_q;
      b_tag_d = a_tag_q | b_tag_q | w_sum[DATA_WIDTH];
    end
  end

  // Pair registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q     <= '0;
      b_q     <= '0;
      a_tag_q <= 1'b0;
      b_tag_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      a_tag_q <= a_tag_d;
      b_tag_q <= b_tag_d;
    end
  end

  assign term_o     = a_q;
  assign term_ovf_o = a_tag_q;

endmodule
`default_nettype wire

// File: rtl/fib_sram_master.sv
`default_nettype none
// ============================================================================
// Module   : fib_sram_master
// Purpose  : Writes Fibonacci terms F(0)..F(n-1) to SRAM addresses 0..n-1
//            on start, and serves single-word host reads while idle, hiding
//            the wrapper's fixed read latency.
// Revision : 1.0 - initial release
// ============================================================================
module fib_sram_master
  import fib_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o,
  output logic [ADDR_WIDTH:0]   filled_o,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_ready_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_err_o,
  output logic                  sram_we_o,
  output logic                  sram_oe_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int CW = ADDR_WIDTH + 1;

  state_e                state_q;
  logic [CW-1:0]         n_q;
  logic [CW-1:0]         filled_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;
  logic [3:0]            wait_q;
  logic                  we_q;
  logic                  oe_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ovf_q;
  logic                  ready_q;
  logic                  rd_valid_q;
  logic                  rd_err_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [CW-1:0]         w_n_clamped;
  logic                  w_idle;
  logic                  w_load;
  logic                  w_advance;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_term;
  logic                  w_term_ovf;

  assign w_n_clamped = CW'(clamp_count(32'(count_i), ADDR_WIDTH));
  assign w_idle      = (state_q == ST_IDLE);
  assign w_load      = w_idle && start_i && (w_n_clamped != '0);
  assign w_advance   = (state_q == ST_GEN);
  assign w_last      = ({1'b0, addr_q} == (n_q - CW'(1)));

  fib_term_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_term_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (w_load),
    .advance_i  (w_advance),
    .term_o     (w_term),
    .term_ovf_o (w_term_ovf)
  );

  // Control FSM: generation sequencing, read sequencing and all SRAM drive.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      filled_q   <= '0;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      wait_q     <= '0;
      we_q       <= 1'b0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (start_i) begin
            // start takes priority; a coincident rd_req is not accepted
            n_q      <= w_n_clamped;
            filled_q <= '0;
            ovf_q    <= 1'b0;
            addr_q   <= '0;
            if (w_n_clamped == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ST_GEN;
              we_q    <= 1'b1;
              busy_q  <= 1'b1;
              ready_q <= 1'b0;
            end
          end else if (rd_req_i && ready_q) begin
            state_q   <= ST_RD_ISSUE;
            rd_addr_q <= rd_addr_i;
            addr_q    <= rd_addr_i;
            oe_q      <= 1'b1;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
          end
        end

        ST_GEN: begin
          filled_q <= {1'b0, addr_q} + CW'(1);
          if (w_term_ovf) begin
            ovf_q <= 1'b1;
          end
          if (w_last) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end else begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
          end
        end

        ST_RD_ISSUE: begin
          if (RD_LATENCY < 2) begin
            state_q <= ST_RD_RESP;
            oe_q    <= 1'b0;
          end else begin
            state_q <= ST_RD_WAIT;
            wait_q  <= 4'(RD_LATENCY - 2);
          end
        end

        ST_RD_WAIT: begin
          // oe stays high until the wrapper has registered the data
          if (wait_q == '0) begin
            state_q <= ST_RD_RESP;
            oe_q    <= 1'b0;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end

        ST_RD_RESP: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
          rd_valid_q <= 1'b1;
          if ({1'b0, rd_addr_q} >= filled_q) begin
            rd_err_q  <= 1'b1;
            rd_data_q <= '0;
          end else begin
            rd_err_q  <= 1'b0;
            rd_data_q <= sram_rdata_i;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          we_q    <= 1'b0;
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign overflow_o   = ovf_q;
  assign filled_o     = filled_q;
  assign rd_ready_o   = w_idle && ready_q && !start_i;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign rd_err_o     = rd_err_q;
  assign sram_we_o    = we_q;
  assign sram_oe_o    = oe_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = w_term;

endmodule
`default_nettype wire

// File: tb/tb_fib_sram_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_fib_sram_master
// Purpose  : Directed self-checking bench for fib_sram_master with a
//            byte-wide SRAM wrapper model (2-edge registered read).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fib_sram_master;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   count;
  logic          busy, done, overflow;
  logic [AW:0]   filled;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ready, rd_valid, rd_err;
  logic [DW-1:0] rd_data;
  logic          sram_we, sram_oe;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;

  always #5 clk = ~clk;

  fib_sram_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .count_i(count),
    .busy_o(busy), .done_o(done), .overflow_o(overflow), .filled_o(filled),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_ready_o(rd_ready),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err),
    .sram_we_o(sram_we), .sram_oe_o(sram_oe), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  // SRAM wrapper: address+oe registered on edge 1, data registered on edge 2.
  logic [DW-1:0] mem [16];
  logic          oe_d;
  logic [AW-1:0] addr_d;
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    oe_d   <= sram_oe;
    addr_d <= sram_addr;
    if (oe_d) sram_rdata <= mem[addr_d];
  end

  // Bus monitor, sampled mid-cycle.
  int wr_n = 0, cyc = 0, done_cnt = 0, both_cnt = 0, oe_cnt = 0;
  int wr_addr_log [256];
  int wr_data_log [256];
  int wr_cyc_log  [256];
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n === 1'b1) begin
      if (sram_we && wr_n < 256) begin
        wr_addr_log[wr_n] = int'(sram_addr);
        wr_data_log[wr_n] = int'(sram_wdata);
        wr_cyc_log[wr_n]  = cyc;
        wr_n = wr_n + 1;
      end
      if (done) done_cnt = done_cnt + 1;
      if (sram_we && sram_oe) both_cnt = both_cnt + 1;
      if (sram_oe) oe_cnt = oe_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int fib_exp [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start a generation run and check the full write stream and final status.
  task automatic run_gen(input int cnt, input int exp_n, input int exp_ovf, input string tag);
    int base_w, base_d, bad, lat;
    bit seen;
    base_w = wr_n;
    base_d = done_cnt;
    @(negedge clk);
    start = 1'b1;
    count = (AW+1)'(cnt);
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    lat  = -1;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (done) begin
        seen = 1'b1;
        lat  = t;
      end else begin
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_done_latency"}, lat, exp_n);
    @(negedge clk);
    chk({tag, "_writes"}, wr_n - base_w, exp_n);
    bad = 0;
    for (int k = 0; k < exp_n; k++) begin
      if (base_w + k < wr_n) begin
        if (wr_addr_log[base_w+k] != k) bad++;
        if (wr_data_log[base_w+k] != fib_exp[k]) bad++;
        if (wr_cyc_log[base_w+k] - wr_cyc_log[base_w] != k) bad++;
      end
    end
    chk({tag, "_write_stream_bad"}, bad, 0);
    chk({tag, "_done_pulses"}, done_cnt - base_d, 1);
    chk({tag, "_filled"}, 32'(filled), exp_n);
    chk({tag, "_overflow"}, 32'(overflow), exp_ovf);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  // Issue one host read and check latency, data and error flag.
  task automatic do_read(input int a, input int exp_d, input int exp_e, input string tag);
    int lat;
    bit rdy;
    rdy = 1'b0;
    for (int t = 0; t < 10 && !rdy; t++) begin
      if (rd_ready) rdy = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_ready"}, 32'(rdy), 32'd1);
    rd_req  = 1'b1;
    rd_addr = AW'(a);
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      rd_req = 1'b0;
      if (rd_valid) lat = k;
    end
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_data"}, 32'(rd_data), exp_d);
    chk({tag, "_err"}, 32'(rd_err), exp_e);
  endtask

  initial begin
    int base_w, base_oe, nerr;
    bit seen;
    fib_exp = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    rst_n = 1'b0; start = 1'b0; count = '0; rd_req = 1'b0; rd_addr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done_ovf_valid_err", {28'd0, done, overflow, rd_valid, rd_err}, 0);
    chk("rst_filled", 32'(filled), 0);
    chk("rst_rd_ready", 32'(rd_ready), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_we_oe", {30'd0, sram_we, sram_oe}, 0);
    chk("rst_addr_wdata", {20'd0, sram_addr, sram_wdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rd_ready", 32'(rd_ready), 1);

    // Ten terms, then a valid read and an out-of-range read
    run_gen(10, 10, 0, "gen10");
    do_read(7, 13, 0, "rd7");
    do_read(12, 0, 1, "rd12");

    run_gen(14, 14, 0, "gen14");
    do_read(13, 233, 0, "rd13");
    run_gen(16, 16, 1, "gen16");
    do_read(14, 121, 0, "rd14");
    do_read(15, 98, 0, "rd15");
    run_gen(20, 16, 1, "gen20_clamp");

    // Zero terms: done next cycle, no writes, overflow cleared
    run_gen(0, 0, 0, "gen0");

    // start and rd_req together: start wins, and rd_req is never taken in GEN
    @(negedge clk);
    base_w  = wr_n;
    base_oe = oe_cnt;
    start   = 1'b1;
    count   = 5'd16;
    rd_req  = 1'b1;
    rd_addr = 4'd2;
    #1;
    chk("collide_rd_ready", 32'(rd_ready), 0);
    @(negedge clk);
    start = 1'b0;
    chk("collide_gen_we", 32'(sram_we), 1);
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (done) begin
        seen   = 1'b1;
        rd_req = 1'b0;
      end else begin
        chk("collide_rd_ready_gen", 32'(rd_ready), 0);
        @(negedge clk);
      end
    end
    rd_req = 1'b0;
    chk("collide_done_seen", 32'(seen), 1);
    @(negedge clk);
    chk("collide_no_oe", oe_cnt - base_oe, 0);
    chk("collide_writes", wr_n - base_w, 16);
    chk("collide_overflow", 32'(overflow), 1);

    // Asynchronous reset in the middle of generation
    @(negedge clk);
    start = 1'b1;
    count = 5'd10;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (sram_we && sram_addr == 4'd5) seen = 1'b1;
      else @(negedge clk);
    end
    chk("midrst_reached_i5", 32'(seen), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_we", 32'(sram_we), 0);
    chk("midrst_filled", 32'(filled), 0);
    chk("midrst_overflow", 32'(overflow), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nerr = 0;
    for (int a = 0; a <= 5; a++) begin
      do_read(a, 0, 1, "midrst_rd");
      if (rd_err) nerr++;
    end
    chk("midrst_err_count", nerr, 6);
    chk("midrst_overflow_after", 32'(overflow), 0);

    run_gen(3, 3, 0, "gen3");
    do_read(2, 1, 0, "rd2_after3");
    do_read(3, 0, 1, "rd3_after3");

    chk("we_oe_overlap", both_cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fib_sram_master.md
Name: fib_sram_master

Overview:
- Initiator for the byte-wide SRAM wrapper port (we/oe/address/data_in/data_out).
- On a start command it generates Fibonacci terms F(0)..F(n-1) and writes term i to SRAM address i, one write per cycle.
- In IDLE it serves single-word host reads back from SRAM and compensates for the wrapper's 2-edge read latency.
- Sits between the top-level control/IO logic and the sram wrapper instance.

Parameters:
- ADDR_WIDTH, 4, SRAM address width; capacity 2^ADDR_WIDTH terms.
- DATA_WIDTH, 8, term/data width; arithmetic is modulo 2^DATA_WIDTH.
- RD_LATENCY, 2, clock edges from address+oe presented to sram_rdata valid; fixed at 2 for the current wrapper.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: begin generation.
- count  in  ADDR_WIDTH+1  number of terms n; values above 2^ADDR_WIDTH are clamped to 2^ADDR_WIDTH.
- busy  out  1  high while generating or serving a read.
- done  out  1  one-cycle pulse when generation completes.
- overflow  out  1  sticky: some written term's true value was >= 2^DATA_WIDTH.
- filled  out  ADDR_WIDTH+1  number of valid terms currently in SRAM.
- rd_req  in  1  host read request.
- rd_addr  in  ADDR_WIDTH  host read index.
- rd_ready  out  1  read request can be accepted this cycle.
- rd_valid  out  1  one-cycle pulse: rd_data/rd_err are valid.
- rd_data  out  DATA_WIDTH  read result.
- rd_err  out  1  rd_addr >= filled; rd_data forced to 0.
- sram_we  out  1  to wrapper we.
- sram_oe  out  1  to wrapper oe.
- sram_addr  out  ADDR_WIDTH  to wrapper address.
- sram_wdata  out  DATA_WIDTH  to wrapper data_in.
- sram_rdata  in  DATA_WIDTH  from wrapper data_out.

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All outputs 0: busy, done, overflow, filled, rd_ready (low during reset; high in IDLE after reset), rd_valid, rd_data, rd_err, sram_we, sram_oe, sram_addr, sram_wdata.
  - SRAM contents are not cleared; filled=0, so every old location reads back with rd_err=1.
- States: IDLE, GEN, RD_ISSUE, RD_WAIT, RD_RESP.
- IDLE:
  - rd_ready = !start. start wins over a simultaneous rd_req, and that rd_req is not accepted.
  - start with n=0: done pulses the next cycle, filled=0, overflow cleared, no writes.
  - start with n>=1: a=0, b=1, i=0, filled=0, overflow=0, next state GEN.
- GEN (busy=1, rd_ready=0, one term per cycle):
  - sram_we=1, sram_oe=0, sram_addr=i, sram_wdata=a.
  - On each edge: a<=b, b<=(a+b) mod 2^DATA_WIDTH, i<=i+1, filled<=i+1.
  - Each of a and b carries an overflow tag. A sum inherits its operands' tags OR the carry-out. overflow is set when a tagged term is written.
  - After writing i=n-1: done pulses for 1 cycle, state returns to IDLE. Total: n GEN cycles.
  - start during GEN is ignored.
- Reads:
  - Accepted on an edge where rd_req && rd_ready; rd_addr is latched at that edge.
  - RD_ISSUE (1 cycle): sram_addr=latched addr, sram_oe=1, sram_we=0.
  - RD_WAIT (RD_LATENCY-1 cycles): same drive, sram_oe held high so the wrapper registers data.
  - RD_RESP (1 cycle): rd_valid=1 and rd_data=sram_rdata, or rd_err=1 with rd_data=0 if the latched addr >= filled. Then IDLE.
  - rd_valid rises 3 cycles after the accept edge. Back-to-back reads: one per 4 cycles.
- When no write or read is in progress, sram_we=0, sram_oe=0 and sram_addr holds its last value.
- sram_we and sram_oe are never high in the same cycle.
- count is sampled only at start.

Decomposition:
- Shared constants in fib_pkg: state encodings, RD_LATENCY default, clamp helper for count.
- One sub-module, fib_term_gen: holds the a/b registers with overflow tags; load/advance controls; outputs the current term and its tag.
- The FSM, read path and SRAM drive stay in fib_sram_master.
- The testbench instantiates the real sram wrapper.

Test Plan:
- Reset, then start with count=10 -> 10 consecutive we cycles, addr 0..9, data 0,1,1,2,3,5,8,13,21,34; done pulses once; filled=10; overflow=0.
- After count=10, reads at addr 7 and addr 12 -> addr 7: rd_valid 3 cycles after accept, rd_data=13, rd_err=0. Addr 12: rd_err=1, rd_data=0.
- count=14 -> last term 233 at addr 13, overflow=0. count=16 -> addr14=121, addr15=98, overflow=1. count=20 is clamped to 16.
- start and rd_req in the same IDLE cycle -> rd_ready=0, generation starts, no read issued. rd_req during GEN is never accepted.
- rst_n low mid-GEN at i=5, then reads of addr 0..5 -> every response has rd_err=1, overflow=0. A subsequent start with count=3 works normally.
- count=0 -> done one cycle after start, no sram_we, filled=0.
